// File: rtl/reg_writeback.sv
// Write-back stage for the integer register file: arbitrates ALU results against
// buffered load responses and tracks loads whose results are still outstanding.
module reg_writeback #(
  parameter int LD_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_wd,
  output logic        o_alu_ready,
  input  logic        i_ld_valid,
  input  logic [4:0]  i_ld_rd,
  input  logic [31:0] i_ld_wd,
  output logic        o_ld_ready,
  input  logic        i_iss_load,
  input  logic [4:0]  i_iss_rd,
  input  logic [4:0]  i_chk_rs1,
  input  logic [4:0]  i_chk_rs2,
  input  logic [4:0]  i_chk_rd,
  output logic        o_hazard,
  output logic        o_Wen,
  output logic [4:0]  o_Wnum,
  output logic [31:0] o_Wd
);

  typedef logic [4:0]  reg_t;
  typedef logic [31:0] data_t;

  localparam int PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  function automatic logic is_pending(input logic [31:0] pend, input reg_t r);
    return (r != 5'd0) && pend[r];
  endfunction

  reg_t             fifo_rd_q [LD_DEPTH];
  data_t            fifo_wd_q [LD_DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]      pending_q, pending_d;
  logic             wen_q, wen_d;
  reg_t             wnum_q, wnum_d;
  data_t            wd_q, wd_d;

  logic  full, push, pop, alu_win;
  reg_t  head_rd, win_rd;
  data_t head_wd, win_wd;

  always_comb begin
    full    = (cnt_q == CNT_W'(LD_DEPTH));
    push    = i_ld_valid && !full;
    // A full FIFO must drain, otherwise ALU traffic could starve loads forever.
    alu_win = i_alu_valid && !full;
    pop     = (cnt_q != '0) && !alu_win;
    head_rd = fifo_rd_q[rd_ptr_q];
    head_wd = fifo_wd_q[rd_ptr_q];
    win_rd  = alu_win ? i_alu_rd : head_rd;
    win_wd  = alu_win ? i_alu_wd : head_wd;

    wen_d  = (alu_win || pop) && (win_rd != 5'd0);
    wnum_d = wen_d ? win_rd : wnum_q;
    wd_d   = wen_d ? win_wd : wd_q;

    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    // Set after clear so a same-register issue keeps the bit pending.
    pending_d = pending_q;
    if (pop)        pending_d[head_rd]  = 1'b0;
    if (i_iss_load) pending_d[i_iss_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  assign o_ld_ready  = !full;
  assign o_alu_ready = !full;
  assign o_hazard    = is_pending(pending_q, i_chk_rs1) |
                       is_pending(pending_q, i_chk_rs2) |
                       is_pending(pending_q, i_chk_rd);
  assign o_Wen  = wen_q;
  assign o_Wnum = wnum_q;
  assign o_Wd   = wd_q;

  // ---- register stage: control and write-port outputs ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pending_q <= '0;
      wen_q     <= 1'b0;
      wnum_q    <= '0;
      wd_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pending_q <= pending_d;
      wen_q     <= wen_d;
      wnum_q    <= wnum_d;
      wd_q      <= wd_d;
    end
  end

  // FIFO storage needs no reset; the count decides which entries are live.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q] <= i_ld_rd;
      fifo_wd_q[wr_ptr_q] <= i_ld_wd;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed and randomized checks of reg_writeback against a queue-based reference model.
module tb_reg_writeback;
  localparam int LD_DEPTH = 4;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_alu_valid;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_wd;
  logic        o_alu_ready;
  logic        i_ld_valid;
  logic [4:0]  i_ld_rd;
  logic [31:0] i_ld_wd;
  logic        o_ld_ready;
  logic        i_iss_load;
  logic [4:0]  i_iss_rd;
  logic [4:0]  i_chk_rs1, i_chk_rs2, i_chk_rd;
  logic        o_hazard;
  logic        o_Wen;
  logic [4:0]  o_Wnum;
  logic [31:0] o_Wd;

  always #5 clk = ~clk;

  reg_writeback #(.LD_DEPTH(LD_DEPTH)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_wd(i_alu_wd),
    .o_alu_ready(o_alu_ready),
    .i_ld_valid(i_ld_valid), .i_ld_rd(i_ld_rd), .i_ld_wd(i_ld_wd),
    .o_ld_ready(o_ld_ready),
    .i_iss_load(i_iss_load), .i_iss_rd(i_iss_rd),
    .i_chk_rs1(i_chk_rs1), .i_chk_rs2(i_chk_rs2), .i_chk_rd(i_chk_rd),
    .o_hazard(o_hazard),
    .o_Wen(o_Wen), .o_Wnum(o_Wnum), .o_Wd(o_Wd)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  ent_t        m_q[$];
  bit          m_pend[32];
  logic        m_wen;
  logic [4:0]  m_wnum;
  logic [31:0] m_wd;
  bit          m_known = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_hazard(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return (a != 0 && m_pend[a]) || (b != 0 && m_pend[b]) || (c != 0 && m_pend[c]);
  endfunction

  task automatic settle();
    #1;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic cycle();
    ent_t w;
    bit   has_w, ld_w, rdy;
    #1;
    rdy = (m_q.size() != LD_DEPTH);
    if (m_known) begin
      chk("ld_ready",  o_ld_ready,  rdy);
      chk("alu_ready", o_alu_ready, rdy);
      chk("hazard",    o_hazard,    m_hazard(i_chk_rs1, i_chk_rs2, i_chk_rd));
    end
    if (i_rst) begin
      m_q.delete();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_wen = 1'b0; m_wnum = '0; m_wd = '0;
      m_known = 1'b1;
    end else begin
      has_w = 1'b0; ld_w = 1'b0; w = '0;
      if (!rdy || (m_q.size() > 0 && !i_alu_valid)) begin
        w = m_q.pop_front(); has_w = 1'b1; ld_w = 1'b1;
      end else if (i_alu_valid) begin
        w.rd = i_alu_rd; w.wd = i_alu_wd; has_w = 1'b1;
      end
      if (i_ld_valid && rdy) m_q.push_back({i_ld_rd, i_ld_wd});
      if (ld_w) m_pend[w.rd] = 1'b0;
      if (i_iss_load) m_pend[i_iss_rd] = 1'b1;
      m_pend[0] = 1'b0;
      m_wen = has_w && (w.rd != 0);
      if (m_wen) begin m_wnum = w.rd; m_wd = w.wd; end
    end
    @(posedge clk); #1;
    if (m_known) begin
      chk("wen",  o_Wen,  m_wen);
      chk("wnum", o_Wnum, m_wnum);
      chk("wd",   o_Wd,   m_wd);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_alu_valid = 0; i_alu_rd = 0; i_alu_wd = 0;
    i_ld_valid = 0; i_ld_rd = 0; i_ld_wd = 0; i_iss_load = 0; i_iss_rd = 0;
    i_chk_rs1 = 0; i_chk_rs2 = 0; i_chk_rd = 0;
    cycle();
    cycle();
    chk("rst_wen", o_Wen, 0);
    chk("rst_wnum", o_Wnum, 0);
    chk("rst_wd", o_Wd, 0);
    chk("rst_ld_ready", o_ld_ready, 1);
    chk("rst_alu_ready", o_alu_ready, 1);
    chk("rst_hazard", o_hazard, 0);
    i_rst = 1'b0;

    // ALU only
    i_alu_valid = 1; i_alu_rd = 5; i_alu_wd = 32'hDEADBEEF;
    cycle();
    i_alu_valid = 0;
    chk("alu_wen", o_Wen, 1);
    chk("alu_wnum", o_Wnum, 5);
    chk("alu_wd", o_Wd, 32'hDEADBEEF);
    cycle();
    chk("alu_wen_drop", o_Wen, 0);

    // Load hazard
    i_iss_load = 1; i_iss_rd = 7;
    cycle();
    i_iss_load = 0; i_chk_rs1 = 7;
    settle();
    chk("ld_haz_set", o_hazard, 1);
    cycle(); cycle();
    i_ld_valid = 1; i_ld_rd = 7; i_ld_wd = 32'h1234;
    cycle();
    i_ld_valid = 0;
    settle();
    chk("ld_haz_pushed", o_hazard, 1);
    cycle();
    chk("ld_wen", o_Wen, 1);
    chk("ld_wnum", o_Wnum, 7);
    chk("ld_wd", o_Wd, 32'h1234);
    chk("ld_haz_clr", o_hazard, 0);
    i_chk_rs1 = 0;

    // Priority and starvation
    i_alu_valid = 1; i_alu_rd = 10; i_alu_wd = 32'hA0;
    for (int k = 1; k <= 4; k++) begin
      i_ld_valid = 1; i_ld_rd = 5'(k); i_ld_wd = 32'h100 + k;
      cycle();
      chk("prio_alu_wnum", o_Wnum, 10);
    end
    i_ld_valid = 0;
    settle();
    chk("full_alu_ready", o_alu_ready, 0);
    chk("full_ld_ready", o_ld_ready, 0);
    cycle();
    chk("drain_wnum1", o_Wnum, 1);
    chk("drain_wd1", o_Wd, 32'h101);
    chk("after_drain_alu_ready", o_alu_ready, 1);
    i_alu_valid = 0;
    for (int k = 2; k <= 4; k++) begin
      cycle();
      chk("drain_wnum", o_Wnum, 5'(k));
      chk("drain_wd", o_Wd, 32'h100 + k);
    end

    // x0 handling
    i_alu_valid = 1; i_alu_rd = 0; i_alu_wd = 32'hFFFFFFFF;
    cycle();
    i_alu_valid = 0;
    chk("x0_alu_wen", o_Wen, 0);
    chk("x0_alu_wnum_held", o_Wnum, 4);
    i_ld_valid = 1; i_ld_rd = 0; i_ld_wd = 32'h55;
    cycle();
    i_ld_valid = 0;
    cycle();
    chk("x0_ld_wen", o_Wen, 0);
    i_chk_rs1 = 0;
    settle();
    chk("x0_hazard", o_hazard, 0);
    chk("x0_consumed", o_ld_ready, 1);

    // Set/clear collision
    i_iss_load = 1; i_iss_rd = 9;
    cycle();
    i_iss_load = 0; i_ld_valid = 1; i_ld_rd = 9; i_ld_wd = 32'h99;
    cycle();
    i_ld_valid = 0; i_iss_load = 1; i_iss_rd = 9;
    cycle();
    i_iss_load = 0; i_chk_rs2 = 9;
    settle();
    chk("coll_wen", o_Wen, 1);
    chk("coll_wnum", o_Wnum, 9);
    chk("coll_hazard", o_hazard, 1);
    i_chk_rs2 = 0;

    // Reset mid-operation
    i_alu_valid = 1; i_alu_rd = 12; i_alu_wd = 32'hC;
    for (int k = 0; k < 3; k++) begin
      i_ld_valid = 1; i_ld_rd = 5'(20 + k); i_ld_wd = 32'h200 + k;
      i_iss_load = (k < 2); i_iss_rd = 5'(13 + k);
      cycle();
    end
    i_ld_valid = 0; i_iss_load = 0; i_alu_valid = 0;
    i_rst = 1;
    cycle();
    i_rst = 0; i_chk_rs1 = 13; i_chk_rs2 = 14; i_chk_rd = 9;
    settle();
    chk("mrst_wen", o_Wen, 0);
    chk("mrst_ld_ready", o_ld_ready, 1);
    chk("mrst_hazard", o_hazard, 0);
    i_alu_valid = 1; i_alu_rd = 3; i_alu_wd = 32'h42;
    cycle();
    i_alu_valid = 0;
    chk("mrst_alu_wen", o_Wen, 1);
    chk("mrst_alu_wnum", o_Wnum, 3);
    chk("mrst_alu_wd", o_Wd, 32'h42);
    cycle();
    chk("mrst_no_stale", o_Wen, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] r;
      i_rst       = ($urandom_range(99) == 0);
      i_alu_valid = ($urandom_range(1) == 1);
      i_alu_rd    = 5'($urandom_range(15));
      i_alu_wd    = $urandom;
      i_ld_valid  = ($urandom_range(9) < 6);
      i_ld_rd     = 5'($urandom_range(15));
      i_ld_wd     = $urandom;
      r           = 5'($urandom_range(15));
      i_iss_load  = !m_pend[r] && ($urandom_range(9) < 3);
      i_iss_rd    = r;
      i_chk_rs1   = 5'($urandom_range(15));
      i_chk_rs2   = 5'($urandom_range(15));
      i_chk_rd    = 5'($urandom_range(15));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back unit that owns the single write port of the integer register file. It merges single-cycle ALU results with variable-latency load responses, buffering loads in a small FIFO. It drives the registered write strobe, register number and data into the register file. It also keeps a pending-load scoreboard so issue logic can stall on load-use hazards.

## Interface
Parameters:
- LD_DEPTH, 4, load-response FIFO depth; power of two, at least 2.

Ports:
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_alu_valid  in  1  ALU result present.
- i_alu_rd  in  5 (reg_t)  ALU destination register.
- i_alu_wd  in  32 (data_t)  ALU result.
- o_alu_ready  out  1  ALU result accepted this cycle.
- i_ld_valid  in  1  load response present.
- i_ld_rd  in  5  load destination register.
- i_ld_wd  in  32  load data.
- o_ld_ready  out  1  FIFO can accept a load response.
- i_iss_load  in  1  a load with destination i_iss_rd issues this cycle.
- i_iss_rd  in  5  destination of the issuing load.
- i_chk_rs1, i_chk_rs2, i_chk_rd  in  5 each  operands of the instruction in decode.
- o_hazard  out  1  a checked register has a pending load.
- o_Wen  out  1  register-file write enable.
- o_Wnum  out  5  register-file write address.
- o_Wd  out  32  register-file write data.

## Operation
- Load FIFO: LD_DEPTH entries of {rd, wd}, with a count of clog2(LD_DEPTH)+1 bits. Push when i_ld_valid && o_ld_ready. o_ld_ready = (count != LD_DEPTH), combinational from count. Pointers wrap modulo LD_DEPTH.
- Arbitration: one winner per cycle.
  - FULL_DRAIN: count == LD_DEPTH. The FIFO head wins and o_alu_ready = 0.
  - ALU: count < LD_DEPTH and i_alu_valid. The ALU wins and o_alu_ready = 1.
  - LD: no ALU valid and count > 0. The FIFO head wins (pop).
  - IDLE: nothing to write.
- o_alu_ready = (count != LD_DEPTH), combinational. It does not depend on i_alu_valid.
- Simultaneous push and pop: count is unchanged. A push into an empty FIFO cannot pop in the same cycle; the entry is visible from the next cycle.
- Pushing when count == LD_DEPTH is blocked by o_ld_ready = 0. The source must hold the response until ready.
- Write to x0: the winner is consumed (ALU accepted or FIFO popped), but o_Wen stays 0.
- Scoreboard: 32 pending bits; bit 0 is hardwired 0.
  - Set bit i_iss_rd when i_iss_load is high.
  - Clear bit rd when a load entry wins arbitration, not when it is pushed.
  - If set and clear hit the same register in one cycle, set wins.
  - ALU writes never touch the scoreboard.
- o_hazard = pending[rs1] | pending[rs2] | pending[rd] for nonzero register numbers, combinational. Issuing a load to an already-pending rd is illegal; issue logic prevents it using o_hazard.
- Forwarding: o_Wen/o_Wnum/o_Wd are also routed to decode bypass. The register file returns the old value on a same-cycle read.

## Timing
- Latency: the winner in cycle N appears on o_Wen/o_Wnum/o_Wd in cycle N+1, held for exactly one cycle.
- A load response pushed in cycle N wins at the earliest in N+1 and is written in N+2.
- The scoreboard clear takes effect in cycle N+1, so o_hazard drops in the same cycle the write is presented.
- o_Wnum and o_Wd keep their last values when o_Wen = 0.
- Reset (i_rst high at an edge), after that edge:
  - o_Wen = 0, o_Wnum = 0, o_Wd = 0.
  - FIFO empty, all pointers 0.
  - Scoreboard all 0, so o_hazard = 0.
  - o_ld_ready = 1 and o_alu_ready = 1.
- Reset mid-operation discards buffered loads and pending bits. No write is presented in the cycle after reset.
- Ready and hazard outputs are combinational from state plus the check inputs only. There is no combinational path from i_ld_valid or i_alu_valid to any ready output.

## Test plan
- ALU only: i_alu_valid with rd=5, wd=0xDEADBEEF in cycle 1 -> o_Wen=1, o_Wnum=5, o_Wd=0xDEADBEEF in cycle 2; o_Wen=0 in cycle 3.
- Load hazard: i_iss_load rd=7 in cycle 1 -> o_hazard=1 for i_chk_rs1=7 from cycle 2. Load response rd=7, wd=0x1234 pushed in cycle 5 -> write in cycle 7, and o_hazard=0 in cycle 7.
- Priority and starvation: i_alu_valid held continuously while 4 load responses are pushed (rd=1..4).
  - ALU wins every cycle until count reaches 4.
  - Then o_alu_ready=0 and o_ld_ready=0, and the FIFO head is written.
  - After that pop, o_alu_ready=1, and the FIFO drains in order 1,2,3,4 as the ALU idles.
- x0 handling: ALU rd=0 wd=0xFFFFFFFF and load rd=0 -> both consumed, o_Wen never asserts; i_chk_rs1=0 never raises o_hazard.
- Set/clear collision: a load for rd=9 wins in the same cycle that i_iss_load rd=9 issues -> write presented, but pending[9] remains 1 and o_hazard stays 1 for rs2=9.
- Reset mid-operation: with 3 FIFO entries and 2 pending bits, assert i_rst for one cycle -> next cycle o_Wen=0, o_ld_ready=1, o_hazard=0; subsequent ALU rd=3 wd=0x42 writes normally 1 cycle later.
